// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter in front of one uart_tx serializer
// Optional requester-index tag byte ahead of each packet: define UART_ARB_TAG_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_finish
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
`ifdef UART_ARB_TAG_EN
    S_TAG,
    S_WAIT_TAG,
`endif
    S_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic               last_q, last_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [NUM_REQ-1:0] req_ready_d;
  logic               busy_d;
  logic [7:0]         tx_data_d;
  logic               tx_start_d;

  logic               found;
  logic [IW-1:0]      sel_idx;
  logic [IW-1:0]      scan;
  logic [7:0]         lane;

  assign lane = req_data[{gidx_q, 3'b000} +: 8];

  // Upward search from the pointer; wrap by explicit compare so non-power-of-2 counts work.
  always_comb begin
    found   = 1'b0;
    sel_idx = ptr_q;
    scan    = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[scan]) begin
        found   = 1'b1;
        sel_idx = scan;
      end
      scan = (scan == IW'(NUM_REQ - 1)) ? '0 : scan + IW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    last_d      = last_q;
    grant_d     = grant;
    tx_data_d   = tx_data;
    tx_start_d  = 1'b0;
    req_ready_d = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gidx_d           = sel_idx;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
`ifdef UART_ARB_TAG_EN
          state_d          = S_TAG;
`else
          state_d          = S_SEND;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      S_TAG: begin
        tx_data_d  = 8'h80 | 8'(gidx_q);
        tx_start_d = 1'b1;
        state_d    = S_WAIT_TAG;
      end
      S_WAIT_TAG: begin
        if (tx_finish) state_d = S_SEND;
      end
`endif
      S_SEND: begin
        if (req_valid[gidx_q]) begin
          tx_data_d           = lane;
          tx_start_d          = 1'b1;
          req_ready_d[gidx_q] = 1'b1;
          last_d              = req_last[gidx_q];
          state_d             = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tx_finish) begin
          if (last_q) begin
            grant_d = '0;
            ptr_d   = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);
            state_d = S_IDLE;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      last_q    <= 1'b0;
      grant     <= '0;
      req_ready <= '0;
      busy      <= 1'b0;
      tx_data   <= 8'h00;
      tx_start  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      last_q    <= last_d;
      grant     <= grant_d;
      req_ready <= req_ready_d;
      busy      <= busy_d;
      tx_data   <= tx_data_d;
      tx_start  <= tx_start_d;
    end
  end

endmodule
